// File: rtl/dr_byte_fetcher.sv
// dr_byte_fetcher: fetches 1-4 memory bytes MSB-first and shifts them into the data register
module dr_byte_fetcher #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [2:0]        NumBytes,
    input  logic              Signed,
    input  logic              LittleEnd,
    input  logic              Abort,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic [7:0]        MemData,
    output logic [7:0]        DR_I,
    output logic              DR_E,
    output logic [1:0]        DR_FunSel,
    output logic              Busy,
    output logic              Done
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, FIN} state_t;
    localparam int WW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam logic [ADDR_W-1:0] ONE = 1;
    state_t state, state_nxt;
    logic [WW-1:0] wcnt;
    logic [2:0] n, idx, n_in;
    logic sgn, le, wait_end, start_ok;
    assign n_in = NumBytes > 3'd4 ? 3'd4 : NumBytes;
    assign wait_end = state == WAIT && wcnt == WW'(MEM_LAT - 1);
    assign start_ok = state == IDLE && Start;
    always_comb begin
        state_nxt = state;
        MemRead = 1'b0;
        DR_E = 1'b0;
        DR_FunSel = 2'b00;
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            IDLE: state_nxt = Start ? (n_in == 3'd0 ? FIN : REQ) : IDLE;
            REQ: begin
                MemRead = 1'b1;
                Busy = 1'b1;
                state_nxt = Abort ? IDLE : WAIT;
            end
            WAIT: begin
                Busy = 1'b1;
                state_nxt = Abort ? IDLE : wait_end ? LOAD : WAIT;
            end
            LOAD: begin
                Busy = 1'b1;
                DR_E = 1'b1;
                DR_FunSel = idx == 3'd0 ? (sgn ? 2'b00 : 2'b01) : 2'b10;
                state_nxt = Abort ? IDLE : (idx + 3'd1 < n) ? REQ : FIN;
            end
            FIN: begin
                Done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // MemAddr only moves when a REQ is about to be issued, so it holds otherwise
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            MemAddr <= '0;
            DR_I <= '0;
            n <= '0;
            idx <= '0;
            wcnt <= '0;
            sgn <= 1'b0;
            le <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt <= state == WAIT ? wcnt + WW'(1) : '0;
            if (wait_end && !Abort) DR_I <= MemData;
            if (start_ok) begin
                n <= n_in;
                sgn <= Signed;
                le <= LittleEnd;
                idx <= '0;
            end
            if (start_ok && n_in != 3'd0) MemAddr <= LittleEnd ? Addr + ADDR_W'(n_in - 3'd1) : Addr;
            if (state == LOAD) idx <= idx + 3'd1;
            if (state == LOAD && state_nxt == REQ) MemAddr <= le ? MemAddr - ONE : MemAddr + ONE;
        end
    end
endmodule

// File: tb/tb_dr_byte_fetcher.sv
// tb_dr_byte_fetcher: scoreboard bench with a latency-accurate byte memory and a data-register model
module tb_dr_byte_fetcher;
    localparam int AW = 16;
    localparam int LAT = 2;
    logic Clock = 1'b0;
    always #5 Clock = ~Clock;
    logic Reset, Start, Signed, LittleEnd, Abort, MemRead, DR_E, Busy, Done;
    logic [AW-1:0] Addr, MemAddr;
    logic [2:0] NumBytes;
    logic [7:0] MemData, DR_I;
    logic [1:0] DR_FunSel;
    int checks = 0, failures = 0;
    int rd_cnt = 0, de_cnt = 0, done_cnt = 0;
    logic [AW-1:0] addr_q[$];
    logic [1:0] fs_q[$];
    logic [31:0] dr_q[$];
    logic [31:0] dr = 32'h0;
    logic [7:0] mem [0:65535];
    logic [7:0] pipe [LAT];
    logic [AW-1:0] ea;
    logic [1:0] ef;
    logic [31:0] ev;

    dr_byte_fetcher #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Addr(Addr), .NumBytes(NumBytes),
        .Signed(Signed), .LittleEnd(LittleEnd), .Abort(Abort), .MemAddr(MemAddr),
        .MemRead(MemRead), .MemData(MemData), .DR_I(DR_I), .DR_E(DR_E),
        .DR_FunSel(DR_FunSel), .Busy(Busy), .Done(Done)
    );

    always @(posedge Clock) begin
        pipe[0] <= MemRead ? mem[MemAddr] : 8'hxx;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign MemData = pipe[LAT-1];

    always @(negedge Clock) begin
        if (MemRead === 1'b1) begin
            rd_cnt++;
            checks++;
            if (addr_q.size() == 0) begin
                failures++;
                $display("FAIL memaddr: unexpected read at %h", MemAddr);
            end else begin
                ea = addr_q.pop_front();
                if (MemAddr !== ea) begin
                    failures++;
                    $display("FAIL memaddr: got %h want %h", MemAddr, ea);
                end
            end
        end
        if (DR_E === 1'b1) begin
            de_cnt++;
            checks++;
            if (fs_q.size() == 0) begin
                failures++;
                $display("FAIL funsel: unexpected DR_E funsel %b", DR_FunSel);
            end else begin
                ef = fs_q.pop_front();
                if (DR_FunSel !== ef) begin
                    failures++;
                    $display("FAIL funsel: got %b want %b", DR_FunSel, ef);
                end
            end
            dr = DR_FunSel == 2'b00 ? {{24{DR_I[7]}}, DR_I} :
                 DR_FunSel == 2'b01 ? {24'h0, DR_I} :
                 DR_FunSel == 2'b10 ? {dr[23:0], DR_I} : dr;
        end
        if (Done === 1'b1) begin
            done_cnt++;
            checks++;
            if (dr_q.size() == 0) begin
                failures++;
                $display("FAIL done: unexpected Done, dr %h", dr);
            end else begin
                ev = dr_q.pop_front();
                if (dr !== ev) begin
                    failures++;
                    $display("FAIL dr_value: got %h want %h", dr, ev);
                end
            end
        end
    end

    task automatic start_xfer(input logic [AW-1:0] a, input logic [2:0] nb, input logic s, input logic l);
        int n;
        logic [31:0] v;
        n = nb > 3'd4 ? 4 : int'(nb);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem[l ? a + AW'(i) : a + AW'(n - 1 - i)];
        if (n == 0) v = dr;
        else if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        for (int k = 0; k < n; k++) begin
            addr_q.push_back(l ? a + AW'(n - 1 - k) : a + AW'(k));
            fs_q.push_back(k == 0 ? (s ? 2'b00 : 2'b01) : 2'b10);
        end
        dr_q.push_back(v);
        rd_cnt = 0;
        de_cnt = 0;
        done_cnt = 0;
        @(negedge Clock);
        Addr = a;
        NumBytes = nb;
        Signed = s;
        LittleEnd = l;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (Done !== 1'b1 && lat < 200) begin
            @(negedge Clock);
            lat++;
        end
        #2;
    endtask

    task automatic flush();
        addr_q.delete();
        fs_q.delete();
        dr_q.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        Addr = '0;
        NumBytes = 3'd0;
        Signed = 1'b0;
        LittleEnd = 1'b0;
        #1;
        checks++;
        if ({MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", {MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done});
        end
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if ({MemRead, DR_E, Busy, Done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle: strobes %b want 0000", {MemRead, DR_E, Busy, Done});
        end
    endtask

    task automatic test_be_signed();
        int lat;
        mem[16'h0010] = 8'h80;
        mem[16'h0011] = 8'h12;
        start_xfer(16'h0010, 3'd2, 1'b1, 1'b0);
        wait_done(1, lat);
        checks++;
        if (lat != 9) begin failures++; $display("FAIL be_latency: got %0d want 9", lat); end
        checks++;
        if (dr !== 32'hFFFF8012) begin failures++; $display("FAIL be_dr: got %h want ffff8012", dr); end
        checks++;
        if (de_cnt != 2 || rd_cnt != 2) begin failures++; $display("FAIL be_counts: de %0d rd %0d want 2 2", de_cnt, rd_cnt); end
    endtask

    task automatic test_le_zero();
        int lat;
        mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33;
        mem[16'h0013] = 8'h44;
        start_xfer(16'h0010, 3'd4, 1'b0, 1'b1);
        wait_done(1, lat);
        checks++;
        if (lat != 17) begin failures++; $display("FAIL le_latency: got %0d want 17", lat); end
        checks++;
        if (dr !== 32'h44332211) begin failures++; $display("FAIL le_dr: got %h want 44332211", dr); end
    endtask

    task automatic test_wrap();
        int lat;
        start_xfer(16'hFFFF, 3'd3, 1'b0, 1'b0);
        wait_done(1, lat);
        checks++;
        if (lat != 13) begin failures++; $display("FAIL wrap_latency: got %0d want 13", lat); end
        checks++;
        if (de_cnt != 3) begin failures++; $display("FAIL wrap_de: got %0d want 3", de_cnt); end
    endtask

    task automatic test_n0_n6();
        int lat;
        start_xfer(16'h0050, 3'd0, 1'b1, 1'b0);
        wait_done(1, lat);
        checks++;
        if (lat != 1) begin failures++; $display("FAIL n0_latency: got %0d want 1", lat); end
        checks++;
        if (rd_cnt != 0 || de_cnt != 0) begin failures++; $display("FAIL n0_access: rd %0d de %0d want 0 0", rd_cnt, de_cnt); end
        start_xfer(16'h0020, 3'd6, 1'b1, 1'b1);
        wait_done(1, lat);
        checks++;
        if (lat != 17) begin failures++; $display("FAIL n6_latency: got %0d want 17", lat); end
        checks++;
        if (rd_cnt != 4 || de_cnt != 4) begin failures++; $display("FAIL n6_counts: rd %0d de %0d want 4 4", rd_cnt, de_cnt); end
    endtask

    task automatic test_abort();
        int lat;
        start_xfer(16'h0010, 3'd2, 1'b1, 1'b0);
        repeat (5) @(negedge Clock);
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        #2;
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", Busy); end
        repeat (12) @(negedge Clock);
        #2;
        checks++;
        if (de_cnt != 1 || done_cnt != 0) begin failures++; $display("FAIL abort_counts: de %0d done %0d want 1 0", de_cnt, done_cnt); end
        flush();
        start_xfer(16'h0010, 3'd1, 1'b0, 1'b1);
        wait_done(1, lat);
        checks++;
        if (lat != 5) begin failures++; $display("FAIL abort_restart: latency %0d want 5", lat); end
    endtask

    task automatic test_reset_mid();
        start_xfer(16'h0030, 3'd3, 1'b0, 1'b0);
        repeat (2) @(negedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got %h want 0", {MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done});
        end
        @(negedge Clock);
        Reset = 1'b1;
        flush();
    endtask

    task automatic test_start_ignored();
        int lat;
        start_xfer(16'h0040, 3'd2, 1'b0, 1'b0);
        Start = 1'b1;
        Addr = 16'h1234;
        NumBytes = 3'd4;
        repeat (5) @(negedge Clock);
        Start = 1'b0;
        wait_done(6, lat);
        checks++;
        if (lat != 9) begin failures++; $display("FAIL ignore_latency: got %0d want 9", lat); end
        repeat (10) @(negedge Clock);
        #2;
        checks++;
        if (rd_cnt != 2 || Busy !== 1'b0) begin failures++; $display("FAIL ignore_extra: rd %0d busy %b want 2 0", rd_cnt, Busy); end
    endtask

    task automatic test_back_to_back();
        int lat, n;
        logic [2:0] nb;
        for (int t = 0; t < 10; t++) begin
            nb = 3'($urandom_range(0, 7));
            n = nb > 3'd4 ? 4 : int'(nb);
            start_xfer(AW'($urandom), nb, 1'($urandom), 1'($urandom));
            wait_done(1, lat);
            checks++;
            if (lat != (n == 0 ? 1 : n * (LAT + 2) + 1)) begin
                failures++;
                $display("FAIL b2b_latency[%0d]: got %0d want %0d", t, lat, n == 0 ? 1 : n * (LAT + 2) + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_be_signed();
        test_le_zero();
        test_wrap();
        test_n0_n6();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        checks++;
        if (addr_q.size() != 0 || fs_q.size() != 0 || dr_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d %0d %0d left", addr_q.size(), fs_q.size(), dr_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end
endmodule
